// File: rtl/axi_spy_pkg.sv
// Shared types for the AXI spy drain path: channel tags, output register
// state and the trace word layout seen by debug sinks.
package axi_spy_pkg;

  // Channel tag carried on every trace word.
  typedef enum logic [1:0] {
    CH_AR = 2'd0,
    CH_AW = 2'd1,
    CH_W  = 2'd2,
    CH_R  = 2'd3
  } chan_id_t;

  // Output register occupancy: EMPTY has no word, HOLD presents trace_valid=1.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_t;

  localparam int NUM_CHAN         = 4;
  localparam int STALL_CNT_WIDTH  = 16;

  // Widths of the trace word in the default build (32-bit entries, 16-bit
  // timestamp). Sinks that unpack the stream can use trace_word_t directly.
  localparam int DEF_TS_WIDTH      = 16;
  localparam int DEF_PAYLOAD_WIDTH = 32;

  typedef struct packed {
    chan_id_t                       chan;
    logic [DEF_TS_WIDTH-1:0]        ts;
    logic [DEF_PAYLOAD_WIDTH-1:0]   payload;
  } trace_word_t;

  // Wider of two widths; used to size the shared payload field.
  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-request round-robin arbiter. The search starts at the pointer and
// wraps; the pointer moves to one past the winner only when a grant is issued.
module rr_arb4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [3:0] i_req,
  output logic       o_valid,
  output logic [3:0] o_grant,
  output logic [1:0] o_grant_idx
);

  logic [1:0] r_ptr;
  logic [3:0] w_req_rot;
  logic [1:0] w_off;

  // Rotate requests so the pointer position lands at bit 0.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default first, so no path can infer a latch.
    w_req_rot = i_req;
    unique case (r_ptr)
      2'd0: w_req_rot = i_req;
      2'd1: w_req_rot = {i_req[0],   i_req[3:1]};
      2'd2: w_req_rot = {i_req[1:0], i_req[3:2]};
      2'd3: w_req_rot = {i_req[2:0], i_req[3]};
    endcase
  end

  // Lowest set bit of the rotated vector is the offset of the winner.
  always_comb begin
    w_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_req_rot[k]) w_off = 2'(k);
    end
  end

  // Grant outputs: one-hot only when enabled and something is requesting.
  always_comb begin
    o_valid     = i_en & (|i_req);
    o_grant_idx = r_ptr + w_off;
    o_grant     = o_valid ? (4'b0001 << o_grant_idx) : 4'b0000;
  end

  // Pointer advances past the winner on each issued grant.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      r_ptr <= 2'd0;
    end else if (o_valid) begin
      r_ptr <= o_grant_idx + 2'd1;
    end
  end

endmodule

// File: rtl/axi_spy_drain.sv
// Drains the four AXI spy FIFOs (AR, AW, W, R) round-robin into one
// timestamped valid/ready trace stream, counting cycles the sink stalls.
module axi_spy_drain
  import axi_spy_pkg::*;
#(
  parameter  int ADDR_WIDTH    = 32,
  parameter  int DATA_WIDTH    = 32,
  parameter  int TS_WIDTH      = 16,
  localparam int PAYLOAD_WIDTH = max_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       drain_en,
  input  logic                       ar_empty,
  input  logic [ADDR_WIDTH-1:0]      ar_pop_data,
  output logic                       ar_pop,
  input  logic                       aw_empty,
  input  logic [ADDR_WIDTH-1:0]      aw_pop_data,
  output logic                       aw_pop,
  input  logic                       w_empty,
  input  logic [DATA_WIDTH-1:0]      w_pop_data,
  output logic                       w_pop,
  input  logic                       r_empty,
  input  logic [DATA_WIDTH-1:0]      r_pop_data,
  output logic                       r_pop,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [1:0]                 trace_chan,
  output logic [TS_WIDTH-1:0]        trace_ts,
  output logic [PAYLOAD_WIDTH-1:0]   trace_payload,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  // Trace word at this instance's widths; same field order as trace_word_t.
  typedef struct packed {
    chan_id_t                 chan;
    logic [TS_WIDTH-1:0]      ts;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } trace_reg_t;

  out_state_t                 r_state;
  out_state_t                 w_state_nxt;
  trace_reg_t                 r_word;
  logic [TS_WIDTH-1:0]        r_ts;
  logic [STALL_CNT_WIDTH-1:0] r_stall;

  logic                       w_load_ok;
  logic [3:0]                 w_req;
  logic                       w_gnt_valid;
  logic [3:0]                 w_grant;
  logic [1:0]                 w_gnt_idx;
  chan_id_t                   w_gnt_chan;
  logic [PAYLOAD_WIDTH-1:0]   w_payload;

  // Requests and load permission. The output register can take a new word
  // when empty or when its current word leaves this cycle; reset blocks pops.
  always_comb begin
    w_req      = {~r_empty, ~w_empty, ~aw_empty, ~ar_empty};
    w_load_ok  = ~reset & drain_en & ((r_state == ST_EMPTY) | trace_ready);
    w_gnt_chan = chan_id_t'(w_gnt_idx);
  end

  rr_arb4 u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_load_ok),
    .i_req       (w_req),
    .o_valid     (w_gnt_valid),
    .o_grant     (w_grant),
    .o_grant_idx (w_gnt_idx)
  );

  // Select the granted FIFO head and zero-extend it to the payload width.
  always_comb begin
    w_payload = '0;
    unique case (w_gnt_chan)
      CH_AR: w_payload[ADDR_WIDTH-1:0] = ar_pop_data;
      CH_AW: w_payload[ADDR_WIDTH-1:0] = aw_pop_data;
      CH_W:  w_payload[DATA_WIDTH-1:0] = w_pop_data;
      CH_R:  w_payload[DATA_WIDTH-1:0] = r_pop_data;
    endcase
  end

  // Free-running timestamp, wrapping from all-ones to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // Output register state: EMPTY or HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a grant always lands a word; otherwise an accepted word empties the register.
  always_comb begin
    w_state_nxt = r_state;
    if (w_gnt_valid) begin
      w_state_nxt = ST_HOLD;
    end else if ((r_state == ST_HOLD) && trace_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Trace word register: loads on grant, otherwise holds (including after acceptance).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= '0;
    end else if (w_gnt_valid) begin
      r_word.chan    <= w_gnt_chan;
      r_word.ts      <= r_ts;
      r_word.payload <= w_payload;
    end
  end

  // Sink stall counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if ((r_state == ST_HOLD) && !trace_ready && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_CNT_WIDTH'(1);
    end
  end

  // Outputs: trace fields from the register, pops straight from the grant.
  always_comb begin
    trace_valid   = (r_state == ST_HOLD);
    trace_chan    = r_word.chan;
    trace_ts      = r_word.ts;
    trace_payload = r_word.payload;
    stall_cnt     = r_stall;
    ar_pop        = w_grant[CH_AR];
    aw_pop        = w_grant[CH_AW];
    w_pop         = w_grant[CH_W];
    r_pop         = w_grant[CH_R];
  end

endmodule

// File: tb/tb_axi_spy_drain.sv
// Self-checking bench for axi_spy_drain: FIFO models feed the DUT, a
// scoreboard holds expected trace words pushed at each pop, and a small
// reference model of grant order, valid and stall count runs alongside.
module tb_axi_spy_drain;

  localparam int TS_W = 4;
  localparam int PW   = 32;

  typedef struct packed {
    logic [1:0]      chan;
    logic [TS_W-1:0] ts;
    logic [PW-1:0]   payload;
  } word_t;

  logic            clk;
  logic            reset;
  logic            drain_en;
  logic            trace_ready;
  logic            ar_empty, aw_empty, w_empty, r_empty;
  logic [31:0]     ar_pop_data, aw_pop_data, w_pop_data, r_pop_data;
  logic            ar_pop, aw_pop, w_pop, r_pop;
  logic            trace_valid;
  logic [1:0]      trace_chan;
  logic [TS_W-1:0] trace_ts;
  logic [PW-1:0]   trace_payload;
  logic [15:0]     stall_cnt;

  logic [31:0] q_ar[$], q_aw[$], q_w[$], q_r[$];
  word_t       exp_q[$];
  word_t       acc_q[$];

  logic            m_valid;
  logic [1:0]      m_ptr;
  logic [TS_W-1:0] m_ts;
  logic [15:0]     m_stall;

  int checks;
  int errors;
  int pop_total;

  axi_spy_drain #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TS_WIDTH   (TS_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .drain_en      (drain_en),
    .ar_empty      (ar_empty),
    .ar_pop_data   (ar_pop_data),
    .ar_pop        (ar_pop),
    .aw_empty      (aw_empty),
    .aw_pop_data   (aw_pop_data),
    .aw_pop        (aw_pop),
    .w_empty       (w_empty),
    .w_pop_data    (w_pop_data),
    .w_pop         (w_pop),
    .r_empty       (r_empty),
    .r_pop_data    (r_pop_data),
    .r_pop         (r_pop),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_chan    (trace_chan),
    .trace_ts      (trace_ts),
    .trace_payload (trace_payload),
    .stall_cnt     (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int fifo_size(input int ch);
    case (ch)
      0:       return q_ar.size();
      1:       return q_aw.size();
      2:       return q_w.size();
      default: return q_r.size();
    endcase
  endfunction

  function automatic logic [31:0] fifo_head(input int ch);
    if (fifo_size(ch) == 0) return 32'h0;
    case (ch)
      0:       return q_ar[0];
      1:       return q_aw[0];
      2:       return q_w[0];
      default: return q_r[0];
    endcase
  endfunction

  task automatic push_entry(input int ch, input logic [31:0] data);
    case (ch)
      0:       q_ar.push_back(data);
      1:       q_aw.push_back(data);
      2:       q_w.push_back(data);
      default: q_r.push_back(data);
    endcase
  endtask

  task automatic fifo_pop(input int ch);
    checks++;
    if (fifo_size(ch) == 0) begin
      errors++;
      $display("FAIL pop_on_empty: channel %0d popped while empty", ch);
    end else begin
      case (ch)
        0:       void'(q_ar.pop_front());
        1:       void'(q_aw.pop_front());
        2:       void'(q_w.pop_front());
        default: void'(q_r.pop_front());
      endcase
    end
  endtask

  task automatic drive_fifos();
    ar_empty    = (q_ar.size() == 0);
    aw_empty    = (q_aw.size() == 0);
    w_empty     = (q_w.size() == 0);
    r_empty     = (q_r.size() == 0);
    ar_pop_data = fifo_head(0);
    aw_pop_data = fifo_head(1);
    w_pop_data  = fifo_head(2);
    r_pop_data  = fifo_head(3);
  endtask

  // One clock cycle: sample and check at the falling edge, then advance the
  // FIFO models and reference model just after the rising edge.
  task automatic tick();
    logic [3:0] pops;
    logic [3:0] req;
    logic [3:0] exp_g;
    logic       gv;
    int         gi;
    int         c;
    word_t      got;
    word_t      nw;

    @(negedge clk);
    pops  = {r_pop, w_pop, aw_pop, ar_pop};
    req   = {~r_empty, ~w_empty, ~aw_empty, ~ar_empty};
    exp_g = 4'b0000;
    gv    = 1'b0;
    gi    = 0;
    if (!reset && drain_en && (!m_valid || trace_ready) && (req != 4'b0000)) begin
      for (int k = 0; k < 4; k++) begin
        c = (int'(m_ptr) + k) % 4;
        if (!gv && req[c]) begin
          gv = 1'b1;
          gi = c;
        end
      end
      exp_g[gi] = 1'b1;
    end

    checks++;
    if (pops !== exp_g) begin
      errors++;
      $display("FAIL pop_vector: got %b expected %b at %0t", pops, exp_g, $time);
    end
    checks++;
    if ($countones(pops) > 1) begin
      errors++;
      $display("FAIL pop_onehot: got %b, more than one pop at %0t", pops, $time);
    end
    checks++;
    if (trace_valid !== m_valid) begin
      errors++;
      $display("FAIL trace_valid: got %b expected %b at %0t", trace_valid, m_valid, $time);
    end
    checks++;
    if (stall_cnt !== m_stall) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected %0d at %0t", stall_cnt, m_stall, $time);
    end

    got = {trace_chan, trace_ts, trace_payload};
    if (m_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: trace word chan=%0d shown with nothing expected", trace_chan);
      end else if (got !== exp_q[0]) begin
        errors++;
        $display("FAIL trace_word: got chan=%0d ts=%0d payload=%h expected chan=%0d ts=%0d payload=%h",
                 got.chan, got.ts, got.payload, exp_q[0].chan, exp_q[0].ts, exp_q[0].payload);
      end
      if (trace_ready && !reset) begin
        acc_q.push_back(got);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end

    for (int k = 0; k < 4; k++) begin
      if (pops[k]) begin
        nw.chan    = 2'(k);
        nw.ts      = m_ts;
        nw.payload = fifo_head(k);
        exp_q.push_back(nw);
        pop_total++;
      end
    end

    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 1'b0;
      m_ptr   = 2'd0;
      m_stall = 16'd0;
      m_ts    = '0;
      exp_q.delete();
    end else begin
      if (m_valid && !trace_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (gv) begin
        m_valid = 1'b1;
        m_ptr   = 2'(gi + 1);
      end else if (m_valid && trace_ready) begin
        m_valid = 1'b0;
      end
      m_ts = m_ts + TS_W'(1);
    end
    for (int k = 0; k < 4; k++) begin
      if (pops[k]) fifo_pop(k);
    end
    drive_fifos();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    drain_en    = 1'b1;
    trace_ready = 1'b0;
    push_entry(0, 32'h0BAD_0001);
    drive_fifos();
    tick();
    tick();
    checks++;
    if (trace_valid !== 1'b0 || trace_chan !== 2'd0 || trace_ts !== '0 ||
        trace_payload !== '0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b chan=%0d ts=%0d payload=%h stall=%0d expected all zero",
               trace_valid, trace_chan, trace_ts, trace_payload, stall_cnt);
    end
    void'(q_ar.pop_front());
    drive_fifos();
    reset = 1'b0;
  endtask

  task automatic test_single_entry();
    drain_en    = 1'b1;
    trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    push_entry(0, 32'hDEAD_BEEF);
    drive_fifos();
    #1;
    checks++;
    if (ar_pop !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: ar_pop=%b expected 1", ar_pop);
    end
    tick();
    checks++;
    if (trace_valid !== 1'b1 || trace_chan !== 2'd0 ||
        trace_payload !== 32'hDEAD_BEEF || trace_ts !== TS_W'(5)) begin
      errors++;
      $display("FAIL single_word: got valid=%b chan=%0d payload=%h ts=%0d expected 1 0 deadbeef 5",
               trace_valid, trace_chan, trace_payload, trace_ts);
    end
    tick();
    tick();
  endtask

  task automatic test_fairness();
    int p0;
    reset_pulse();
    drain_en    = 1'b1;
    trace_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int ch = 0; ch < 4; ch++) push_entry(ch, 32'hF000_0000 | (ch << 8) | i);
    end
    drive_fifos();
    acc_q.delete();
    p0 = pop_total;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (pop_total - p0 != 8) begin
      errors++;
      $display("FAIL fair_pops: got %0d pops expected 8", pop_total - p0);
    end
    checks++;
    if (acc_q.size() != 8) begin
      errors++;
      $display("FAIL fair_count: got %0d words expected 8", acc_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (acc_q[i].chan !== 2'(i % 4)) begin
          errors++;
          $display("FAIL fair_order[%0d]: got chan %0d expected %0d", i, acc_q[i].chan, i % 4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int p0;
    reset_pulse();
    drain_en    = 1'b1;
    trace_ready = 1'b0;
    push_entry(0, 32'hA0A0_0000);
    push_entry(0, 32'hA0A0_0001);
    push_entry(1, 32'hB0B0_0000);
    push_entry(1, 32'hB0B0_0001);
    drive_fifos();
    p0 = pop_total;
    for (int i = 0; i < 11; i++) tick();
    checks++;
    if (stall_cnt !== 16'd10) begin
      errors++;
      $display("FAIL bp_stall: got %0d expected 10", stall_cnt);
    end
    checks++;
    if (pop_total - p0 != 1) begin
      errors++;
      $display("FAIL bp_pops: got %0d pops expected 1", pop_total - p0);
    end
    checks++;
    if (trace_valid !== 1'b1 || trace_chan !== 2'd0 || trace_payload !== 32'hA0A0_0000) begin
      errors++;
      $display("FAIL bp_hold: got valid=%b chan=%0d payload=%h expected 1 0 a0a00000",
               trace_valid, trace_chan, trace_payload);
    end
    trace_ready = 1'b1;
    tick();
    checks++;
    if (trace_valid !== 1'b1 || trace_chan !== 2'd1 || trace_payload !== 32'hB0B0_0000) begin
      errors++;
      $display("FAIL bp_resume: got valid=%b chan=%0d payload=%h expected 1 1 b0b00000",
               trace_valid, trace_chan, trace_payload);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_drain_gating();
    int p0;
    reset_pulse();
    drain_en    = 1'b1;
    trace_ready = 1'b1;
    push_entry(0, 32'h1000_0001);
    push_entry(1, 32'h2000_0001);
    drive_fifos();
    for (int i = 0; i < 4; i++) tick();
    drain_en = 1'b0;
    push_entry(2, 32'h3000_0001);
    push_entry(3, 32'h4000_0001);
    drive_fifos();
    p0 = pop_total;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pop_total != p0 || trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL gate_idle: got pops=%0d valid=%b expected 0 0", pop_total - p0, trace_valid);
    end
    drain_en = 1'b1;
    #1;
    checks++;
    if (w_pop !== 1'b1 || r_pop !== 1'b0) begin
      errors++;
      $display("FAIL gate_resume: got w_pop=%b r_pop=%b expected 1 0", w_pop, r_pop);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_ts_wrap();
    int budget;
    drain_en    = 1'b1;
    trace_ready = 1'b1;
    budget      = 0;
    while (m_ts != TS_W'(15) && budget < 20) begin
      tick();
      budget++;
    end
    checks++;
    if (m_ts != TS_W'(15)) begin
      errors++;
      $display("FAIL wrap_budget: counter position %0d not reached 15", m_ts);
    end
    push_entry(0, 32'h5555_0000);
    push_entry(0, 32'h5555_0001);
    drive_fifos();
    acc_q.delete();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (acc_q.size() < 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d words expected 2", acc_q.size());
    end else if (acc_q[0].ts !== TS_W'(15) || acc_q[1].ts !== TS_W'(0)) begin
      errors++;
      $display("FAIL wrap_ts: got %0d,%0d expected 15,0", acc_q[0].ts, acc_q[1].ts);
    end
  endtask

  task automatic test_stall_saturation();
    reset_pulse();
    drain_en    = 1'b1;
    trace_ready = 1'b0;
    push_entry(2, 32'h7777_0000);
    drive_fifos();
    for (int i = 0; i < 70001; i++) tick();
    checks++;
    if (stall_cnt !== 16'hFFFF || trace_valid !== 1'b1 || trace_chan !== 2'd2) begin
      errors++;
      $display("FAIL sat_stall: got stall=%h valid=%b chan=%0d expected ffff 1 2",
               stall_cnt, trace_valid, trace_chan);
    end
  endtask

  task automatic test_reset_mid_op();
    push_entry(0, 32'h1111_0001);
    push_entry(3, 32'h3333_0001);
    drive_fifos();
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    trace_ready = 1'b1;
    checks++;
    if (trace_valid !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset_state: got valid=%b stall=%0d expected 0 0", trace_valid, stall_cnt);
    end
    #1;
    checks++;
    if (ar_pop !== 1'b1 || r_pop !== 1'b0) begin
      errors++;
      $display("FAIL midreset_rr: got ar_pop=%b r_pop=%b expected 1 0", ar_pop, r_pop);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (exp_q.size() != 0 || q_ar.size() != 0 || q_r.size() != 0) begin
      errors++;
      $display("FAIL drain_done: got %0d expected words left, ar=%0d r=%0d entries, expected 0",
               exp_q.size(), q_ar.size(), q_r.size());
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    pop_total   = 0;
    m_valid     = 1'b0;
    m_ptr       = 2'd0;
    m_stall     = 16'd0;
    m_ts        = '0;
    reset       = 1'b1;
    drain_en    = 1'b0;
    trace_ready = 1'b0;
    drive_fifos();

    test_reset();
    test_single_entry();
    test_fairness();
    test_backpressure();
    test_drain_gating();
    test_ts_wrap();
    test_stall_saturation();
    test_reset_mid_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_spy_drain.md
Name: axi_spy_drain

Overview:
Downstream consumer of the four AXI spy FIFOs (AR, AW, W, R). Round-robin arbitrates among the non-empty FIFOs and pops one entry per grant. Tags each entry with its channel ID and a free-running timestamp, then presents it on a single valid/ready trace stream for a debug sink (trace buffer, UART or JTAG bridge).

Parameters:
ADDR_WIDTH, 32, width of AR/AW FIFO entries
DATA_WIDTH, 32, width of W/R FIFO entries
TS_WIDTH, 16, timestamp counter width
PAYLOAD_WIDTH, max(ADDR_WIDTH,DATA_WIDTH), trace payload width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
drain_en  in  1  1 = grants allowed; 0 = no new pops
ar_empty  in  1  AR spy FIFO empty
ar_pop_data  in  ADDR_WIDTH  AR FIFO head entry
ar_pop  out  1  AR FIFO pop strobe
aw_empty / aw_pop_data / aw_pop  in/in/out  1/ADDR_WIDTH/1  same for AW
w_empty / w_pop_data / w_pop  in/in/out  1/DATA_WIDTH/1  same for W
r_empty / r_pop_data / r_pop  in/in/out  1/DATA_WIDTH/1  same for R
trace_valid  out  1  trace word valid
trace_ready  in  1  sink accepts trace word
trace_chan  out  2  channel tag: 0=AR, 1=AW, 2=W, 3=R
trace_ts  out  TS_WIDTH  timestamp at grant
trace_payload  out  PAYLOAD_WIDTH  entry, zero-extended
stall_cnt  out  16  saturating count of cycles with trace_valid=1 and trace_ready=0

Behaviour:
- Reset (sync, active-high): trace_valid=0, trace_chan=0, trace_ts=0, trace_payload=0, stall_cnt=0, all *_pop=0, timestamp=0, RR pointer=AR. Reset overrides all other inputs on the same edge. An in-flight word is discarded and no pop occurs in the reset cycle.
- FIFO contract: first-word-fall-through. *_pop_data is valid whenever *_empty=0. A pop removes the head on the same rising edge. *_pop is never asserted while *_empty=1.
- Timestamp: free-running TS_WIDTH counter, +1 every cycle, wraps from all-ones to 0.
- Output register state: EMPTY (trace_valid=0) or HOLD (trace_valid=1).
- load_ok = drain_en & (EMPTY | (trace_valid & trace_ready)).
- Grant: when load_ok and at least one FIFO is non-empty, pick the first non-empty channel starting at the RR pointer, in order AR, AW, W, R, wrapping. The grant is combinational in that cycle.
- On a grant cycle:
  - assert exactly one *_pop, combinationally, in that cycle;
  - on the edge, load payload (zero-extended), chan, and ts = current counter value;
  - state becomes HOLD;
  - RR pointer becomes granted channel + 1 (mod 4).
- No grant and trace_valid & trace_ready: go to EMPTY, clear trace_valid, hold other trace_* values.
- HOLD with trace_ready=0: all trace_* outputs stable, no pops, stall_cnt += 1 saturating at 16'hFFFF.
- Throughput: one word per cycle when trace_ready is held at 1 and FIFOs are non-empty. Grant-to-trace_valid latency is 1 cycle.
- drain_en=0: no grants. A held word stays until accepted, then state becomes EMPTY. The RR pointer is unchanged.
- A channel going non-empty in the same cycle as a grant is evaluated the next cycle.
- At most one pop per cycle across all four channels.

Decomposition:
- Package axi_spy_pkg:
  - chan_id_t, a 2-bit enum CH_AR=0, CH_AW=1, CH_W=2, CH_R=3;
  - trace word struct {chan, ts, payload};
  - STALL_CNT_WIDTH=16.
- One natural sub-module: rr_arb4 (4-request round-robin arbiter with one-hot grant and pointer update on enable). Reusable for other spy aggregation.

Test Plan:
- Single entry: after reset, AR non-empty with data 32'hDEAD_BEEF, trace_ready=1, drain_en=1 at cycle 5 -> ar_pop=1 in cycle 5; cycle 6 trace_valid=1, chan=0, payload=DEADBEEF, ts=5.
- Fairness: all four FIFOs hold 2 entries, trace_ready=1 -> trace_chan sequence 0,1,2,3,0,1,2,3 on consecutive cycles, 8 pops total, never two pops in one cycle.
- Backpressure: trace_ready=0 for 10 cycles while HOLD and FIFOs non-empty -> outputs stable, no pops, stall_cnt=10; raise trace_ready -> next word appears the following cycle.
- drain_en gating: W and R non-empty, drain_en=0 -> no pops, trace_valid stays 0. Raise drain_en -> W granted first (pointer at W after a prior AW grant).
- Wrap and saturation: TS_WIDTH=4, grant at counter 15 then at the next cycle -> ts=15 then ts=0. Hold stall for 70000 cycles -> stall_cnt=16'hFFFF.
- Reset mid-operation: assert reset while HOLD with trace_ready=0 -> next cycle trace_valid=0, stall_cnt=0, no pop; RR restarts at AR.
